map_sst_dump: RTL and testbench
===============================

# map_sst_dump

Save-state reader for mapper register banks. It walks the mapper's save-state read port at addresses 0..127 and captures each returned byte. The bytes go out as a valid/ready stream toward the host-side save-state buffer. Byte 127, the mapper index, is checked against the expected value, and any mismatch is flagged.

## Interface
Parameters:
- SETTLE, 2, clock cycles `sst_addr` is held before `sst_di` is sampled. Legal range 1..15.
- LAST_ADDR, 127, address of the final byte. This byte carries the mapper index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a dump. Sampled only in IDLE.
- map_idx_exp  in  8  expected mapper index. Latched on accepted start.
- sst_addr  out  8  save-state register address driven to the mapper
- sst_oe  out  1  save-state read strobe. High while a dump is active.
- sst_di  in  8  byte returned by the mapper for `sst_addr`
- out_data  out  8  captured byte
- out_valid  out  1  `out_data` is valid
- out_ready  in  1  sink accepts the byte when `out_valid` and `out_ready` are both high
- out_last  out  1  high together with `out_valid` for the byte at LAST_ADDR
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at dump completion
- err_idx  out  1  byte LAST_ADDR differed from the latched `map_idx_exp`. Sticky until the next accepted start.

## Operation
- Registered outputs are all 0 after reset: `sst_addr`, `sst_oe`, `out_data`, `out_valid`, `out_last`, `busy`, `done`, `err_idx`.
- States:
  - IDLE: wait for `start`.
  - SETUP: address driven, settle counter running.
  - EMIT: byte presented on the output stream.
  - FIN: completion.
- IDLE:
  - On `start=1`: latch `map_idx_exp`, set `sst_addr=0`, `sst_oe=1`, `busy=1`, clear `err_idx`, load the settle counter with SETTLE-1, go to SETUP.
- SETUP:
  - While the counter is nonzero, decrement it.
  - When the counter is 0: `out_data <= sst_di`, `out_last <= (sst_addr==LAST_ADDR)`, `out_valid <= 1`, go to EMIT.
  - If `sst_addr==LAST_ADDR`, also set `err_idx <= (sst_di != latched idx)` in the same cycle.
- EMIT:
  - Hold `out_data`, `out_last` and `sst_addr` stable until the handshake.
  - On handshake: `out_valid <= 0`.
    - If `out_last`: go to FIN.
    - Otherwise: `sst_addr <= sst_addr+1`, reload the counter, go to SETUP.
- FIN:
  - `done=1` for this single cycle.
  - Set `sst_oe=0`, `busy=0`, `out_last=0`, `sst_addr=0`, then go to IDLE.
- Address arithmetic is 8-bit and never passes LAST_ADDR. Addresses LAST_ADDR+1..255 are never driven.
- `start` while not in IDLE is ignored and has no side effects.
- `rst` at any state returns to IDLE with all outputs at reset values on the next edge. Any partial stream is abandoned without `out_last` or `done`.
- `sst_di` is sampled only in the final SETUP cycle of each address. Changes at any other time are ignored.

## Timing
- `start` sampled at edge 0. SETUP for address 0 spans cycles 1..SETTLE.
- First `out_valid` appears at cycle SETTLE+1.
- With `out_ready` tied high, each byte costs SETTLE+1 cycles.
- Full dump: last EMIT at cycle 128·(SETTLE+1); `done` at cycle 128·(SETTLE+1)+1. For SETTLE=2 these are cycles 384 and 385.
- `out_ready` low stretches EMIT only. Every cycle of backpressure adds one cycle to the total.
- `busy` is high from cycle 1 through the FIN cycle inclusive. `start` is accepted again from the cycle after FIN.
- Combinational path from `out_ready`: the handshake decision only. No output changes in the same cycle.

## Test plan
- Basic dump, SETTLE=2, ready high: the mapper model returns `addr^8'h5A` for 0..126 and 0x04 at 127, with map_idx_exp=0x04.
  - Required: 128 bytes in address order (0x5A, 0x5B, ...).
  - Required: `out_last` only on 0x04; `done` at cycle 385; `err_idx`=0.
- Backpressure: `out_ready` random with 50% duty.
  - Required: `out_data`, `out_last` and `sst_addr` are stable across every stalled cycle.
  - Required: byte sequence is identical to the basic dump; total cycles = 385 + number of stall cycles.
- Index mismatch: model returns 0x04 at address 127 with map_idx_exp=0x05.
  - Required: `err_idx` rises with the last byte capture and stays 1 after `done`.
  - Required: `err_idx` clears on the next accepted start.
- Start while busy: pulse `start` at byte 10 with map_idx_exp=0x99.
  - Required: stream is unaffected; the comparison still uses the originally latched value.
- Reset mid-dump: assert `rst` during EMIT of byte 40.
  - Required: next cycle all outputs are 0, with no `done` or `out_last`.
  - Required: a new start dumps again from address 0.
- SETTLE=1 and SETTLE=15:
  - Required: `done` at cycles 257 and 2049 respectively with ready high.
  - Required: `sst_di` is sampled in the last SETUP cycle only. Verify by toggling `sst_di` in earlier cycles.

Source files
------------

// File: rtl/map_sst_dump_if.sv
// Save-state read port and host-side byte stream for map_sst_dump.
// master = the dump engine; slave = mapper plus stream sink.
interface map_sst_dump_if;
    logic [7:0] sst_addr;
    logic       sst_oe;
    logic [7:0] sst_di;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output sst_addr,
        output sst_oe,
        output out_data,
        output out_valid,
        output out_last,
        input  sst_di,
        input  out_ready
    );

    modport slave (
        input  sst_addr,
        input  sst_oe,
        input  out_data,
        input  out_valid,
        input  out_last,
        output sst_di,
        output out_ready
    );
endinterface

// File: rtl/map_sst_dump.sv
// Walks mapper save-state addresses 0..LAST_ADDR, streams each byte out,
// and flags a mismatch between the final (mapper index) byte and the expected one.
module map_sst_dump #(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned LAST_ADDR = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           map_idx_exp,
    map_sst_dump_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_idx
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0] LAST     = 8'(LAST_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EMIT,
        FIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       oe_q, oe_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       hs;

    // out_ready only feeds this handshake term; every output is registered.
    assign hs = (state_q == EMIT) && valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            oe_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oe_d    = oe_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = map_idx_exp;
                    addr_d  = '0;
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = bus.sst_di;
                    last_d  = (addr_q == LAST);
                    valid_d = 1'b1;
                    if (addr_q == LAST) begin
                        err_d = (bus.sst_di != idx_q);
                    end
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        cnt_d   = CNT_LOAD;
                        state_d = SETUP;
                    end
                end
            end
            FIN: begin
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sst_addr  = addr_q;
    assign bus.sst_oe    = oe_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_idx       = err_q;

endmodule

// File: tb/tb_map_sst_dump.sv
// Randomized bench for map_sst_dump against a timestamp-based model,
// covering SETTLE = 2, 1 and 15 with three instances.
module tb_map_sst_dump;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] idx_exp = 8'h00;
    logic       st_a[3];
    logic [7:0] di_a[3];
    logic [7:0] addr_a[3];
    logic       oe_a[3];
    logic [7:0] data_a[3];
    logic       valid_a[3];
    logic       last_a[3];
    logic       busy_a[3];
    logic       done_a[3];
    logic       err_a[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        map_sst_dump_if bus ();
        assign bus.sst_di    = di_a[g];
        assign bus.out_ready = rdy;
        map_sst_dump #(.SETTLE(S), .LAST_ADDR(127)) u_dut (
            .clk(clk),
            .rst(rst),
            .start(st_a[g]),
            .map_idx_exp(idx_exp),
            .bus(bus),
            .busy(busy_a[g]),
            .done(done_a[g]),
            .err_idx(err_a[g])
        );
        assign addr_a[g]  = bus.sst_addr;
        assign oe_a[g]    = bus.sst_oe;
        assign data_a[g]  = bus.out_data;
        assign valid_a[g] = bus.out_valid;
        assign last_a[g]  = bus.out_last;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;
    logic [7:0] m127 = 8'h04;
    logic [7:0] got[$];

    // model: phase 0 idle, 1 dumping, 2 completion cycle
    int ecnt    = 0;
    int m_ph    = 0;
    int m_k     = 0;
    int m_nv    = 0;
    int m_E     = 0;
    int m_D     = 0;
    int m_stall = 0;
    int m_dn    = 0;
    logic [7:0] m_lat = 8'h00;
    logic       m_err = 1'b0;

    function automatic int settle(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 15);
    endfunction

    function automatic logic [7:0] mem(input int a);
        return (a == 127) ? m127 : (8'(a) ^ 8'h5A);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    // mapper: correct byte only in the final settle cycle, noise otherwise
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) di_a[i] = 8'($urandom);
        if (m_ph == 1 && ecnt + 1 == m_nv)
            di_a[sel] = mem(int'(addr_a[sel]));
    end

    always @(posedge clk) begin
        int e;
        int s;
        bit r;
        bit st;
        bit rd;
        bit stall;
        bit ev;
        logic [7:0] pd;
        logic [7:0] pa;
        logic pl;
        int ea;
        ecnt++;
        e = ecnt;
        s = settle(sel);
        r = rst;
        st = st_a[sel];
        rd = rdy;
        stall = valid_a[sel] && !rd;
        pd = data_a[sel];
        pa = addr_a[sel];
        pl = last_a[sel];
        if (!r && valid_a[sel] && rd) got.push_back(data_a[sel]);
        if (r) begin
            m_ph = 0;
            m_k = 0;
            m_err = 1'b0;
        end else begin
            case (m_ph)
                0: if (st) begin
                    m_ph = 1;
                    m_k = 0;
                    m_lat = idx_exp;
                    m_nv = e + s;
                    m_err = 1'b0;
                    m_E = e;
                    m_stall = 0;
                end
                1: if (e > m_nv) begin
                    if (rd) begin
                        if (m_k == 127) begin
                            m_ph = 2;
                            m_D = e;
                            m_dn++;
                        end else begin
                            m_k++;
                            m_nv = e + s;
                        end
                    end else begin
                        m_stall++;
                    end
                end
                default: m_ph = 0;
            endcase
            if (m_ph == 1 && e == m_nv && m_k == 127)
                m_err = (mem(127) != m_lat);
        end
        #1;
        ev = (m_ph == 1 && e >= m_nv);
        ea = (m_ph == 1) ? m_k : ((m_ph == 2) ? 127 : 0);
        chk("busy", busy_a[sel], m_ph != 0);
        chk("oe", oe_a[sel], m_ph != 0);
        chk("done", done_a[sel], m_ph == 2);
        chk("valid", valid_a[sel], ev);
        chk("addr", addr_a[sel], ea);
        chk("err", err_a[sel], m_err);
        if (ev) begin
            chk("data", data_a[sel], mem(m_k));
            chk("last", last_a[sel], m_k == 127);
        end
        if (stall && !r) begin
            chk("stall_data", data_a[sel], pd);
            chk("stall_addr", addr_a[sel], pa);
            chk("stall_last", last_a[sel], pl);
        end
    end

    task automatic do_dump(input int s_i, input logic [7:0] ix, input logic [7:0] m,
                           input bit bp, input bit poke, input int rst_k,
                           input int exp_dur, input logic err_exp);
        int budget;
        int dn0;
        bit poked;
        bit did_rst;
        @(negedge clk);
        sel = s_i;
        m127 = m;
        idx_exp = ix;
        rdy = 1'b1;
        got.delete();
        dn0 = m_dn;
        st_a[s_i] = 1'b1;
        @(negedge clk);
        st_a[s_i] = 1'b0;
        chk("err_clr", err_a[s_i], 0);
        chk("busy_on", busy_a[s_i], 1);
        budget = 0;
        poked = 1'b0;
        did_rst = 1'b0;
        while (m_dn == dn0 && budget < 5000) begin
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && !poked && m_k == 10) begin
                st_a[s_i] = 1'b1;
                idx_exp = 8'h99;
                poked = 1'b1;
            end else begin
                st_a[s_i] = 1'b0;
            end
            if (rst_k >= 0 && m_k == rst_k && valid_a[s_i]) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                did_rst = 1'b1;
                chk("rst_valid", valid_a[s_i], 0);
                chk("rst_last", last_a[s_i], 0);
                chk("rst_done", done_a[s_i], 0);
                chk("rst_data", data_a[s_i], 0);
                chk("rst_addr", addr_a[s_i], 0);
                chk("rst_oe", oe_a[s_i], 0);
                chk("rst_busy", busy_a[s_i], 0);
                break;
            end
            @(negedge clk);
            budget++;
        end
        st_a[s_i] = 1'b0;
        rdy = 1'b1;
        if (!did_rst) begin
            chk("timeout", budget < 5000, 1);
            chk("cycles", m_D - m_E + 1, exp_dur + (bp ? m_stall : 0));
            chk("nbytes", got.size(), 128);
            if (got.size() == 128) begin
                chk("byte0", got[0], 8'h5A);
                chk("byte1", got[1], 8'h5B);
                chk("byte127", got[127], m);
                for (int i = 0; i < 127; i++)
                    chk("byte_seq", got[i], 8'(i) ^ 8'h5A);
            end
            chk("err_final", err_a[s_i], err_exp);
            @(negedge clk);
            chk("busy_off", busy_a[s_i], 0);
            chk("err_hold", err_a[s_i], err_exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) st_a[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_addr", addr_a[i], 0);
            chk("reset_oe", oe_a[i], 0);
            chk("reset_data", data_a[i], 0);
            chk("reset_valid", valid_a[i], 0);
            chk("reset_last", last_a[i], 0);
            chk("reset_busy", busy_a[i], 0);
            chk("reset_done", done_a[i], 0);
            chk("reset_err", err_a[i], 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_dump(0, 8'h04, 8'h04, 1'b0, 1'b0, -1, 385, 1'b0);
        do_dump(0, 8'h04, 8'h04, 1'b1, 1'b0, -1, 385, 1'b0);
        do_dump(0, 8'h05, 8'h04, 1'b0, 1'b0, -1, 385, 1'b1);
        do_dump(0, 8'h04, 8'h04, 1'b0, 1'b1, -1, 385, 1'b0);
        do_dump(0, 8'h04, 8'h04, 1'b0, 1'b0, 40, 385, 1'b0);
        do_dump(0, 8'h04, 8'h04, 1'b0, 1'b0, -1, 385, 1'b0);
        do_dump(1, 8'h04, 8'h04, 1'b0, 1'b0, -1, 257, 1'b0);
        do_dump(2, 8'h04, 8'h04, 1'b0, 1'b0, -1, 2049, 1'b0);
        do_dump(2, 8'h04, 8'h04, 1'b1, 1'b0, -1, 2049, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
